// File: rtl/dvi_timing_ctrl.sv
// dvi_timing_ctrl: raster timing generator for the DVI output path.
// Free-running h/v counters walk the ACTIVE, FRONT-PORCH, SYNC and BACK-PORCH
// regions. o_fetch is a registered copy of the raw data-enable, so the pixel
// read pipeline can start early. Every other output is delayed further so that
// o_de arrives P_FETCH_LEAD cycles after o_fetch for the same pixel.
// Run/stop requests only take effect on frame boundaries.
module dvi_timing_ctrl #(
  parameter int P_H_ACTIVE   = 640,
  parameter int P_H_FP       = 16,
  parameter int P_H_SYNC     = 96,
  parameter int P_H_BP       = 48,
  parameter int P_V_ACTIVE   = 480,
  parameter int P_V_FP       = 10,
  parameter int P_V_SYNC     = 2,
  parameter int P_V_BP       = 33,
  parameter int P_HS_POL     = 0,
  parameter int P_VS_POL     = 0,
  parameter int P_FETCH_LEAD = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  output logic o_running,
  output logic o_fetch,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_de,
  output logic [$clog2(P_H_ACTIVE+P_H_FP+P_H_SYNC+P_H_BP)-1:0] o_x,
  output logic [$clog2(P_V_ACTIVE+P_V_FP+P_V_SYNC+P_V_BP)-1:0] o_y,
  output logic o_frame_start,
  output logic o_line_start
);

  localparam int H_TOTAL = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;
  localparam int V_TOTAL = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DEPTH   = P_FETCH_LEAD + 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(P_H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(P_H_ACTIVE + P_H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(P_H_ACTIVE + P_H_FP + P_H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(P_V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(P_V_ACTIVE + P_V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(P_V_ACTIVE + P_V_FP + P_V_SYNC - 1);

  localparam logic HS_ON = (P_HS_POL != 0);
  localparam logic VS_ON = (P_VS_POL != 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  // One pixel's worth of aligned timing information travelling down the delay line.
  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic          fs;
    logic          ls;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
  } pix_t;

  localparam pix_t PIX_IDLE = {~HS_ON, ~VS_ON, 1'b0, 1'b0, 1'b0, {HW{1'b0}}, {VW{1'b0}}};

  state_t        state, state_next;
  logic [HW-1:0] h, h_next;
  logic [VW-1:0] v, v_next;
  logic          running;
  logic          h_last, v_last;
  pix_t          raw_pix;
  pix_t          pipe [DEPTH];

  // State and raster counters; reset parks everything at (0,0) in IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      state <= state_next;
      h     <= h_next;
      v     <= v_next;
    end
  end

  // Next-state and counter advance; a stop request only lands after the last pixel of a frame.
  always_comb begin
    state_next = state;
    h_next     = h;
    v_next     = v;
    h_last     = (h == H_LAST);
    v_last     = (v == V_LAST);
    case (state)
      IDLE: begin
        h_next = '0;
        v_next = '0;
        if (i_enable) state_next = RUN;
      end
      RUN, STOPPING: begin
        if (h_last) begin
          h_next = '0;
          v_next = v_last ? '0 : v + VW'(1);
        end else begin
          h_next = h + HW'(1);
        end
        if (state == RUN) begin
          if (!i_enable) state_next = STOPPING;
        end else if (i_enable) begin
          state_next = RUN;
        end else if (h_last && v_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Raw region decode straight from the counters, gated so nothing asserts while idle.
  always_comb begin
    running    = (state != IDLE);
    raw_pix    = PIX_IDLE;
    raw_pix.de = running && (h < H_ACT) && (v < V_ACT);
    raw_pix.hs = (running && (h >= HS_FIRST) && (h <= HS_LAST)) ? HS_ON : ~HS_ON;
    raw_pix.vs = (running && (v >= VS_FIRST) && (v <= VS_LAST)) ? VS_ON : ~VS_ON;
    raw_pix.fs = running && (h == '0) && (v == '0);
    raw_pix.ls = running && (h == '0);
    raw_pix.x  = h;
    raw_pix.y  = v;
  end

  // Fetch strobe is the raw data-enable one cycle late, ahead of the aligned outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_fetch <= 1'b0;
    else          o_fetch <= raw_pix.de;
  end

  // Delay line keeps shifting even when idle so the tail of a frame drains out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= PIX_IDLE;
    end else begin
      pipe[0] <= raw_pix;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign o_running     = running;
  assign o_hsync       = pipe[DEPTH-1].hs;
  assign o_vsync       = pipe[DEPTH-1].vs;
  assign o_de          = pipe[DEPTH-1].de;
  assign o_frame_start = pipe[DEPTH-1].fs;
  assign o_line_start  = pipe[DEPTH-1].ls;
  assign o_x           = pipe[DEPTH-1].x;
  assign o_y           = pipe[DEPTH-1].y;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// tb_dvi_timing_ctrl: checks dvi_timing_ctrl on a shrunken raster
// (16 clocks x 11 lines) so whole frames fit in a short run.
// A per-cycle reference model pushes expected raw timing into a queue and a
// monitor pops and compares it against the delayed DUT outputs; the tasks add
// targeted timing measurements for start, line, frame, stop and reset.
module tb_dvi_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       ls;
    logic [3:0] x;
    logic [3:0] y;
  } sb_t;

  localparam sb_t IDLE_EXP = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       o_running, o_fetch, o_hsync, o_vsync, o_de, o_frame_start, o_line_start;
  logic [3:0] o_x, o_y;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int  m_state = 0;
  int  m_h = 0;
  int  m_v = 0;
  sb_t sb_q[$];

  dvi_timing_ctrl #(
    .P_H_ACTIVE(HA), .P_H_FP(HF), .P_H_SYNC(HS), .P_H_BP(HB),
    .P_V_ACTIVE(VA), .P_V_FP(VF), .P_V_SYNC(VS), .P_V_BP(VB),
    .P_HS_POL(0), .P_VS_POL(0), .P_FETCH_LEAD(2)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_enable(en),
    .o_running(o_running),
    .o_fetch(o_fetch),
    .o_hsync(o_hsync),
    .o_vsync(o_vsync),
    .o_de(o_de),
    .o_x(o_x),
    .o_y(o_y),
    .o_frame_start(o_frame_start),
    .o_line_start(o_line_start)
  );

  always #5 clk = ~clk;

  // Cycle counter used for period and latency measurements.
  always @(posedge clk) cyc++;

  function automatic sb_t model_raw(input bit run, input int h, input int v);
    sb_t r;
    r.de = run && (h < HA) && (v < VA);
    r.hs = !(run && (h >= HA + HF) && (h < HA + HF + HS));
    r.vs = !(run && (v >= VA + VF) && (v < VA + VF + VS));
    r.fs = run && (h == 0) && (v == 0);
    r.ls = run && (h == 0);
    r.x  = 4'(h);
    r.y  = 4'(v);
    return r;
  endfunction

  // Reference raster model: pushes the expected raw timing of each new cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0;
      m_h = 0;
      m_v = 0;
      sb_q.delete();
      repeat (4) sb_q.push_back(IDLE_EXP);
    end else begin
      if (m_state == 0) begin
        if (en) m_state = 1;
        m_h = 0;
        m_v = 0;
      end else begin
        bit last;
        last = (m_h == HT - 1) && (m_v == VT - 1);
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          m_h = m_h + 1;
        end
        if (m_state == 1) begin
          if (!en) m_state = 2;
        end else if (en) begin
          m_state = 1;
        end else if (last) begin
          m_state = 0;
        end
      end
      sb_q.push_back(model_raw(m_state != 0, m_h, m_v));
    end
  end

  // Scoreboard: fetch lags the raw stream by one cycle, the aligned outputs by three.
  always @(negedge clk) begin
    if (sb_q.size() >= 4) begin
      sb_t exp_out, act_out;
      logic exp_fetch, exp_run;
      exp_out   = sb_q[0];
      exp_fetch = sb_q[2].de;
      exp_run   = (m_state != 0);
      act_out   = {o_de, o_hsync, o_vsync, o_frame_start, o_line_start, o_x, o_y};
      checks++;
      if ({o_fetch, o_running, act_out} !== {exp_fetch, exp_run, exp_out}) begin
        errors++;
        $display("[TB] FAIL scoreboard cyc=%0d: got fetch=%b run=%b out=%h, expected fetch=%b run=%b out=%h",
                 cyc, o_fetch, o_running, act_out, exp_fetch, exp_run, exp_out);
      end
      void'(sb_q.pop_front());
    end
  end

  task automatic test_reset();
    int bad;
    bad = 0;
    rst_n = 1'b0;
    en = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({o_running, o_fetch, o_de, o_hsync, o_vsync, o_x, o_y} !== {3'b000, 2'b11, 8'd0}) begin
      errors++;
      $display("[TB] FAIL reset_values: got %b, expected %b",
               {o_running, o_fetch, o_de, o_hsync, o_vsync, o_x, o_y}, {3'b000, 2'b11, 8'd0});
    end
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if ({o_running, o_fetch, o_de, o_hsync, o_vsync, o_x, o_y} !== {3'b000, 2'b11, 8'd0}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL idle_hold: got %0d non-idle cycles, expected 0", bad);
    end
  endtask

  task automatic test_start();
    int run_len;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_running, o_fetch, o_de} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL start_t1: got run/fetch/de=%b, expected 100", {o_running, o_fetch, o_de});
    end
    @(negedge clk);
    checks++;
    if ({o_fetch, o_de} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL start_t2: got fetch/de=%b, expected 10", {o_fetch, o_de});
    end
    @(negedge clk);
    checks++;
    if (o_de !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_t3: got de=%b, expected 0", o_de);
    end
    @(negedge clk);
    checks++;
    if ({o_de, o_frame_start, o_x, o_y} !== {2'b11, 8'd0}) begin
      errors++;
      $display("[TB] FAIL start_t4: got de/fs/x/y=%b, expected %b",
               {o_de, o_frame_start, o_x, o_y}, {2'b11, 8'd0});
    end
    run_len = 0;
    while (o_de === 1'b1 && run_len < 50) begin
      run_len++;
      @(negedge clk);
    end
    checks++;
    if (run_len !== HA) begin
      errors++;
      $display("[TB] FAIL first_de_run: got %0d cycles, expected %0d", run_len, HA);
    end
  endtask

  task automatic test_frame();
    int n, nf, nd, nls, bad_ls, last_ls, nhs, nvs;
    int hs_x, hs_y, hs_run, vs_x, vs_y, gap_start, gap_len;
    bit hs_seen, hs_done, prev_hs, prev_vs, prev_de;
    n = 0;
    while (o_frame_start !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_frame_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL frame_wait: got no frame_start in %0d cycles, expected one", n);
    end
    nf = 0; nd = 0; nls = 0; bad_ls = 0; last_ls = -1; nhs = 0; nvs = 0;
    hs_x = -1; hs_y = -1; hs_run = 0; vs_x = -1; vs_y = -1; gap_start = 0; gap_len = -1;
    hs_seen = 0; hs_done = 0; prev_hs = 1; prev_vs = 1; prev_de = 1;
    for (int i = 0; i < FRAME; i++) begin
      if (o_fetch) nf++;
      if (o_de) nd++;
      if (o_line_start) begin
        nls++;
        if (last_ls >= 0 && (i - last_ls) != HT) bad_ls++;
        last_ls = i;
      end
      if (!o_hsync) begin
        nhs++;
        if (prev_hs && !hs_seen) begin
          hs_seen = 1;
          hs_x = int'(o_x);
          hs_y = int'(o_y);
        end
        if (!hs_done) hs_run++;
      end else if (hs_seen) begin
        hs_done = 1;
      end
      if (!o_vsync) begin
        nvs++;
        if (prev_vs) begin
          vs_x = int'(o_x);
          vs_y = int'(o_y);
        end
      end
      if (!o_de && prev_de) gap_start = i;
      if (o_de && !prev_de && gap_len < 0) gap_len = i - gap_start;
      prev_hs = o_hsync;
      prev_vs = o_vsync;
      prev_de = o_de;
      @(negedge clk);
    end
    checks++;
    if (nf !== HA * VA) begin errors++; $display("[TB] FAIL fetch_count: got %0d, expected %0d", nf, HA * VA); end
    checks++;
    if (nd !== HA * VA) begin errors++; $display("[TB] FAIL de_count: got %0d, expected %0d", nd, HA * VA); end
    checks++;
    if (nls !== VT || bad_ls !== 0) begin
      errors++;
      $display("[TB] FAIL line_start: got %0d pulses %0d bad periods, expected %0d and 0", nls, bad_ls, VT);
    end
    checks++;
    if (hs_x !== HA + HF || hs_y !== 0 || hs_run !== HS) begin
      errors++;
      $display("[TB] FAIL hsync_first: got x=%0d y=%0d len=%0d, expected x=%0d y=0 len=%0d", hs_x, hs_y, hs_run, HA + HF, HS);
    end
    checks++;
    if (nhs !== HS * VT) begin errors++; $display("[TB] FAIL hsync_total: got %0d, expected %0d", nhs, HS * VT); end
    checks++;
    if (nvs !== VS * HT || vs_x !== 0 || vs_y !== VA + VF) begin
      errors++;
      $display("[TB] FAIL vsync: got len=%0d x=%0d y=%0d, expected len=%0d x=0 y=%0d", nvs, vs_x, vs_y, VS * HT, VA + VF);
    end
    checks++;
    if (gap_len !== HT - HA) begin errors++; $display("[TB] FAIL de_gap: got %0d, expected %0d", gap_len, HT - HA); end
    checks++;
    if (o_frame_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL frame_period: got fs=%b after %0d cycles, expected 1", o_frame_start, FRAME);
    end
  endtask

  task automatic test_stop();
    int n, fs_cyc, bad;
    n = 0;
    while (o_frame_start !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    fs_cyc = cyc;
    n = 0;
    while (o_y !== 4'd2 && n < 400) begin @(negedge clk); n++; end
    en = 1'b0;
    n = 0;
    while (o_running !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (cyc - fs_cyc !== FRAME - 3) begin
      errors++;
      $display("[TB] FAIL stop_frame_end: got running low %0d cycles after frame_start, expected %0d", cyc - fs_cyc, FRAME - 3);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({o_de, o_hsync, o_vsync} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL stop_drain: got de/hs/vs=%b, expected 011", {o_de, o_hsync, o_vsync});
    end
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_fetch !== 1'b0 || o_running !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL stop_quiet: got %0d active cycles, expected 0", bad); end
  endtask

  task automatic test_back_to_back();
    int n, fs_cyc, drops;
    en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (o_frame_start !== 1'b1 && n < 20);
    checks++;
    if (n !== 4 || o_x !== 4'd0 || o_y !== 4'd0) begin
      errors++;
      $display("[TB] FAIL restart: got fs after %0d cycles at (%0d,%0d), expected 4 at (0,0)", n, o_x, o_y);
    end
    fs_cyc = cyc;
    n = 0;
    while (o_y !== 4'd2 && n < 400) begin @(negedge clk); n++; end
    en = 1'b0;
    n = 0;
    while (o_y !== 4'd8 && n < 400) begin @(negedge clk); n++; end
    en = 1'b1;
    drops = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (o_running !== 1'b1) drops++;
    end while (o_frame_start !== 1'b1 && n < 400);
    checks++;
    if (cyc - fs_cyc !== FRAME || drops !== 0) begin
      errors++;
      $display("[TB] FAIL resume: got period %0d with %0d idle cycles, expected %0d and 0", cyc - fs_cyc, drops, FRAME);
    end
  endtask

  task automatic test_async_reset();
    int n, bad;
    n = 0;
    while (!(o_x === 4'd3 && o_y === 4'd1) && n < 400) begin @(negedge clk); n++; end
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    checks++;
    if ({o_running, o_fetch, o_de, o_frame_start, o_line_start, o_hsync, o_vsync, o_x, o_y} !== {5'b0, 2'b11, 8'd0}) begin
      errors++;
      $display("[TB] FAIL async_reset: got %b, expected %b",
               {o_running, o_fetch, o_de, o_frame_start, o_line_start, o_hsync, o_vsync, o_x, o_y}, {5'b0, 2'b11, 8'd0});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_fetch !== 1'b0 || o_running !== 1'b0 || o_de !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL post_reset_idle: got %0d active cycles, expected 0", bad); end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_running, o_fetch} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reenable_t1: got run/fetch=%b, expected 10", {o_running, o_fetch});
    end
    @(negedge clk);
    checks++;
    if (o_fetch !== 1'b1) begin errors++; $display("[TB] FAIL reenable_t2: got fetch=%b, expected 1", o_fetch); end
    repeat (20) @(negedge clk);
    en = 1'b0;
  endtask

  // Hard stop in case something never comes back.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_start();
    test_frame();
    test_stop();
    test_back_to_back();
    test_async_reset();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
